lcd_if_ctrl: RTL

//  Consumer of the processor's LCD output word. Takes a 32-bit command/data word written by the
//  LSU to the LCD port and turns it into HD44780-compatible pin timing (RS setup, EN pulse, hold,

---
 rtl/lcd_if_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/lcd_if_ctrl.sv
// HD44780 pin sequencer: runs the power-up init, then turns accepted LCD words into RS/EN/DATA timing.
// Pins are registered; writes arriving while busy are discarded and flagged on drop_o.
module lcd_if_ctrl #(
   parameter int T_PWRUP_CYC = 750000,
   parameter int T_SETUP_CYC = 2,
   parameter int T_EN_CYC    = 12,
   parameter int T_HOLD_CYC  = 2,
   parameter int T_EXEC_CYC  = 1850,
   parameter int T_CLEAR_CYC = 76000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] lcd_word_i,
   input  logic        lcd_we_i,
   output logic        busy_o,
   output logic        init_done_o,
   output logic        drop_o,
   output logic [7:0]  lcd_data_o,
   output logic        lcd_rs_o,
   output logic        lcd_rw_o,
   output logic        lcd_en_o,
   output logic        lcd_on_o,
   output logic        lcd_blon_o
);

   localparam int M1    = (T_PWRUP_CYC > T_SETUP_CYC) ? T_PWRUP_CYC : T_SETUP_CYC;
   localparam int M2    = (M1 > T_EN_CYC)    ? M1 : T_EN_CYC;
   localparam int M3    = (M2 > T_HOLD_CYC)  ? M2 : T_HOLD_CYC;
   localparam int M4    = (M3 > T_EXEC_CYC)  ? M3 : T_EXEC_CYC;
   localparam int T_MAX = (M4 > T_CLEAR_CYC) ? M4 : T_CLEAR_CYC;
   localparam int CW    = $clog2(T_MAX) + 1;

   // A count of N occupies the state for N cycles; zero behaves as one.
   function automatic logic [CW-1:0] lim(input int n);
      return (n <= 1) ? '0 : CW'(n - 1);
   endfunction

   localparam logic [CW-1:0] L_PWRUP = lim(T_PWRUP_CYC);
   localparam logic [CW-1:0] L_SETUP = lim(T_SETUP_CYC);
   localparam logic [CW-1:0] L_EN    = lim(T_EN_CYC);
   localparam logic [CW-1:0] L_HOLD  = lim(T_HOLD_CYC);
   localparam logic [CW-1:0] L_EXEC  = lim(T_EXEC_CYC);
   localparam logic [CW-1:0] L_CLEAR = lim(T_CLEAR_CYC);

   typedef enum logic [2:0] {
      S_PWRUP, S_LOAD, S_SETUP, S_PULSE, S_HOLD, S_EXEC, S_IDLE
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_ld;
   logic [2:0]      r_idx;
   logic [7:0]      w_init_word;
   logic            w_is_clear;
   logic            w_accept;
   logic [7:0]      r_data;
   logic            r_rs;
   logic            r_en;
   logic            r_on;
   logic            r_blon;
   logic            r_busy;
   logic            r_drop;
   logic            r_init_done;
   logic            w_unused;

   assign w_unused    = ^{lcd_word_i[29:10], lcd_word_i[8]};
   assign w_accept    = (r_state == S_IDLE) && lcd_we_i;
   // Clear/home need the long execution wait.
   assign w_is_clear  = !r_rs && ((r_data == 8'h01) || (r_data == 8'h02));

   always_comb begin
      w_init_word = 8'h38;
      case (r_idx[1:0])
         2'd0: w_init_word = 8'h38;
         2'd1: w_init_word = 8'h0C;
         2'd2: w_init_word = 8'h01;
         2'd3: w_init_word = 8'h06;
         default: w_init_word = 8'h38;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_ld    = '0;
      case (r_state)
         S_PWRUP: if (r_cnt == L_PWRUP) w_state_nxt = S_LOAD;
         S_LOAD: begin
            w_state_nxt = S_SETUP;
            w_cnt_ld    = L_SETUP;
         end
         S_SETUP: if (r_cnt == '0) begin
            w_state_nxt = S_PULSE;
            w_cnt_ld    = L_EN;
         end
         S_PULSE: if (r_cnt == '0) begin
            w_state_nxt = S_HOLD;
            w_cnt_ld    = L_HOLD;
         end
         S_HOLD: if (r_cnt == '0) begin
            w_state_nxt = S_EXEC;
            w_cnt_ld    = w_is_clear ? L_CLEAR : L_EXEC;
         end
         S_EXEC: if (r_cnt == '0) w_state_nxt = (r_idx < 3'd4) ? S_LOAD : S_IDLE;
         S_IDLE: if (lcd_we_i) begin
            w_state_nxt = S_SETUP;
            w_cnt_ld    = L_SETUP;
         end
         default: w_state_nxt = S_PWRUP;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= S_PWRUP;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_data      <= '0;
         r_rs        <= 1'b0;
         r_en        <= 1'b0;
         r_on        <= 1'b1;
         r_blon      <= 1'b0;
         r_busy      <= 1'b1;
         r_drop      <= 1'b0;
         r_init_done <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         // Power-up counts up from the reset value; every other timed state counts down.
         if (w_state_nxt != r_state)  r_cnt <= w_cnt_ld;
         else if (r_state == S_PWRUP) r_cnt <= r_cnt + CW'(1);
         else if (r_cnt != '0)        r_cnt <= r_cnt - CW'(1);

         if (r_state == S_LOAD) begin
            r_data <= w_init_word;
            r_rs   <= 1'b0;
            r_idx  <= r_idx + 3'd1;
         end else if (w_accept) begin
            r_data <= lcd_word_i[7:0];
            r_rs   <= lcd_word_i[9];
            r_on   <= lcd_word_i[31];
            r_blon <= lcd_word_i[30];
         end

         r_en   <= (w_state_nxt == S_PULSE);
         r_busy <= (w_state_nxt != S_IDLE);
         r_drop <= lcd_we_i && r_busy;
         if ((r_state == S_EXEC) && (w_state_nxt == S_IDLE)) r_init_done <= 1'b1;
      end
   end

   assign busy_o      = r_busy;
   assign init_done_o = r_init_done;
   assign drop_o      = r_drop;
   assign lcd_data_o  = r_data;
   assign lcd_rs_o    = r_rs;
   assign lcd_rw_o    = 1'b0;
   assign lcd_en_o    = r_en;
   assign lcd_on_o    = r_on;
   assign lcd_blon_o  = r_blon;

endmodule
